// File: rtl/adsr_pkg.sv
// Shared state codes for the ADSR envelope generator and its debug port.
package adsr_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_ATTACK  = 3'd1;
  localparam logic [ST_W-1:0] ST_DECAY   = 3'd2;
  localparam logic [ST_W-1:0] ST_SUSTAIN = 3'd3;
  localparam logic [ST_W-1:0] ST_RELEASE = 3'd4;

  typedef enum logic [ST_W-1:0] {
    StIdle    = ST_IDLE,
    StAttack  = ST_ATTACK,
    StDecay   = ST_DECAY,
    StSustain = ST_SUSTAIN,
    StRelease = ST_RELEASE
  } adsr_state_e;

endpackage

// File: rtl/lrclk_tick.sv
// Brings the frame clock into the clk domain and emits a one-cycle pulse per rising edge.
module lrclk_tick (
  input  logic clk,
  input  logic rst_n,
  input  logic lrclk,
  output logic tick
);

  logic sync1_q, sync2_q, prev_q, tick_q;

  // tick_q rises on the third clk edge after lrclk goes high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= lrclk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      tick_q  <= sync2_q & ~prev_q;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/adsr_envelope.sv
// Frame-rate ADSR envelope producing an unsigned gain word for the multiplier amplitude input.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int unsigned BITSIZE  = 16,
  parameter int unsigned FRAC     = 8,
  parameter int unsigned RATESIZE = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lrclk,
  input  logic                gate,
  input  logic [RATESIZE-1:0] attack_rate,
  input  logic [RATESIZE-1:0] decay_rate,
  input  logic [BITSIZE-1:0]  sustain_level,
  input  logic [RATESIZE-1:0] release_rate,
  output logic [BITSIZE-1:0]  out,
  output logic                active,
  output logic [ST_W-1:0]     state
);

  localparam int unsigned ACCSIZE = BITSIZE + FRAC;
  localparam logic [ACCSIZE-1:0] ENV_MAX = '1;

  logic tick;

  lrclk_tick u_lrclk_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .lrclk (lrclk),
    .tick  (tick)
  );

  adsr_state_e       state_q, state_d;
  logic [ACCSIZE-1:0] env_q, env_d, target;
  logic [ACCSIZE:0]   attack_ext, decay_ext, release_ext;
  logic [ACCSIZE:0]   sum_att, diff_dec, diff_rel;
  logic               active_q;

  // One extra bit on every operand catches attack carry and decay/release underflow.
  always_comb begin
    attack_ext                  = '0;
    decay_ext                   = '0;
    release_ext                 = '0;
    attack_ext[RATESIZE-1:0]    = attack_rate;
    decay_ext[RATESIZE-1:0]     = decay_rate;
    release_ext[RATESIZE-1:0]   = release_rate;
    target                      = {sustain_level, {FRAC{1'b0}}};
    sum_att                     = {1'b0, env_q} + attack_ext;
    diff_dec                    = {1'b0, env_q} - decay_ext;
    diff_rel                    = {1'b0, env_q} - release_ext;
  end

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (!gate && (state_q inside {StAttack, StDecay, StSustain})) begin
      state_d = StRelease;
    end else if (gate && (state_q inside {StIdle, StRelease})) begin
      // Retrigger keeps the current level so a re-struck note does not click.
      state_d = StAttack;
    end else begin
      unique case (state_q)
        StAttack: begin
          if (attack_rate == '0 || sum_att[ACCSIZE] || sum_att[ACCSIZE-1:0] == ENV_MAX) begin
            env_d   = ENV_MAX;
            state_d = StDecay;
          end else begin
            env_d = sum_att[ACCSIZE-1:0];
          end
        end
        StDecay: begin
          if (decay_rate == '0 || diff_dec[ACCSIZE] || diff_dec[ACCSIZE-1:0] <= target) begin
            env_d   = target;
            state_d = StSustain;
          end else begin
            env_d = diff_dec[ACCSIZE-1:0];
          end
        end
        StSustain: env_d = target;
        StRelease: begin
          if (release_rate == '0 || diff_rel[ACCSIZE] || diff_rel[ACCSIZE-1:0] == '0) begin
            env_d   = '0;
            state_d = StIdle;
          end else begin
            env_d = diff_rel[ACCSIZE-1:0];
          end
        end
        default: env_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      env_q    <= '0;
      active_q <= 1'b0;
    end else if (tick) begin
      state_q  <= state_d;
      env_q    <= env_d;
      active_q <= (state_d != StIdle);
    end
  end

  assign out    = env_q[ACCSIZE-1 -: BITSIZE];
  assign active = active_q;
  assign state  = state_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Randomized and directed bench for adsr_envelope against a frame-level arithmetic model.
module tb_adsr_envelope;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lrclk;
  logic        gate;
  logic [15:0] attack_rate, decay_rate, sustain_level, release_rate;
  logic [15:0] out;
  logic        active;
  logic [2:0]  state;

  adsr_envelope dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lrclk         (lrclk),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .out           (out),
    .active        (active),
    .state         (state)
  );

  always #5 clk = ~clk;

  localparam longint EnvMax = (longint'(1) << 24) - 1;

  int     n_vec = 0;
  int     n_err = 0;
  longint env_m = 0;
  int     st_m  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Envelope rules applied to a plain signed integer level, once per frame.
  task automatic model_tick();
    longint t, nxt;
    t = longint'(sustain_level) << 8;
    if (!gate && (st_m == 1 || st_m == 2 || st_m == 3)) st_m = 4;
    else if (gate && (st_m == 0 || st_m == 4)) st_m = 1;
    else begin
      case (st_m)
        1: begin
          nxt = env_m + longint'(attack_rate);
          if (attack_rate == 0 || nxt >= EnvMax) begin env_m = EnvMax; st_m = 2; end
          else env_m = nxt;
        end
        2: begin
          nxt = env_m - longint'(decay_rate);
          if (decay_rate == 0 || nxt <= t) begin env_m = t; st_m = 3; end
          else env_m = nxt;
        end
        3: env_m = t;
        4: begin
          nxt = env_m - longint'(release_rate);
          if (release_rate == 0 || nxt <= 0) begin env_m = 0; st_m = 0; end
          else env_m = nxt;
        end
        default: env_m = 0;
      endcase
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_out"}, 32'(out), 32'(env_m >> 8));
    check({tag, "_state"}, 32'(state), 32'(st_m));
    check({tag, "_active"}, 32'(active), 32'(st_m != 0));
  endtask

  // One lrclk frame: rise, verify tick timing and tick+1 update, then hold across the fall.
  task automatic do_frame();
    @(negedge clk);
    lrclk = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("tick_early", 32'(dut.u_lrclk_tick.tick), 32'd0);
    check_outputs("pre_tick");
    @(posedge clk);
    #1 check("tick_on", 32'(dut.u_lrclk_tick.tick), 32'd1);
    model_tick();
    @(posedge clk);
    #1 check("tick_off", 32'(dut.u_lrclk_tick.tick), 32'd0);
    check_outputs("post_tick");
    repeat (3) @(posedge clk);
    @(negedge clk);
    lrclk = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("fall_no_tick", 32'(dut.u_lrclk_tick.tick), 32'd0);
    check_outputs("hold");
  endtask

  function automatic logic [15:0] rnd_rate();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'($urandom_range(1, 255));
      2:       return 16'($urandom_range(256, 16'h3FFF));
      default: return 16'($urandom_range(0, 16'hFFFF));
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    lrclk = 1'b0;
    gate = 1'b0;
    attack_rate = '0;
    decay_rate = '0;
    sustain_level = '0;
    release_rate = '0;
    repeat (3) @(posedge clk);
    #1 check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) do_frame();

    attack_rate = 16'hFFFF;
    decay_rate = 16'h8000;
    sustain_level = 16'h8000;
    gate = 1'b1;
    for (int i = 0; i < 300 && (st_m == 0 || st_m == 1); i++) do_frame();
    check("attack_done", 32'(state), 32'd2);
    for (int i = 0; i < 300 && st_m == 2; i++) do_frame();
    check("decay_done", 32'(out), 32'h8000);

    sustain_level = 16'h4000;
    do_frame();
    check("sustain_track", 32'(out), 32'h4000);

    gate = 1'b0;
    release_rate = 16'hFFFF;
    do_frame();
    check("release_enter", 32'(state), 32'd4);
    for (int i = 0; i < 100 && (env_m >> 8) > 64'h2000; i++) do_frame();

    gate = 1'b1;
    attack_rate = 16'h0000;
    do_frame();
    check("retrigger_state", 32'(state), 32'd1);
    do_frame();
    check("instant_attack", 32'(out), 32'hFFFF);

    gate = 1'b0;
    for (int i = 0; i < 300 && st_m != 0; i++) do_frame();
    check("release_to_idle", 32'(out), 32'h0000);

    gate = 1'b1;
    attack_rate = 16'h1234;
    for (int i = 0; i < 4; i++) do_frame();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    env_m = 0;
    st_m = 0;
    check_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    gate = 1'b0;
    do_frame();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) gate = ~gate;
      if ($urandom_range(0, 3) == 0) begin
        attack_rate = rnd_rate();
        decay_rate = rnd_rate();
        release_rate = rnd_rate();
        sustain_level = 16'($urandom_range(0, 16'hFFFF));
      end
      do_frame();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
